// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, LED pattern constants and BCD helper for the lane-catch game
package game_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_INIT = 3'd0,
    S_SET  = 3'd1,
    S_GAME = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;
  localparam logic [63:0] ALT_55 = {32{2'b01}};
  localparam logic [63:0] ALT_AA = {32{2'b10}};
  function automatic logic [7:0] bcd_of(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: player/timing events in, display/LED state out
interface game_ctrl_if #(
  parameter int LANES = 8,
  parameter int LED_W = 16
);
  localparam int POS_W = $clog2(LANES);
  logic start, key_left, key_right, hit, miss, sec_tick, led_tick;
  logic [2:0] state;
  logic [POS_W-1:0] pos;
  logic [7:0] score_bcd, time_bcd;
  logic [1:0] lives;
  logic [LED_W-1:0] led;
  logic done;
  modport master (
    output start, key_left, key_right, hit, miss, sec_tick, led_tick,
    input state, pos, score_bcd, time_bcd, lives, led, done
  );
  modport slave (
    input start, key_left, key_right, hit, miss, sec_tick, led_tick,
    output state, pos, score_bcd, time_bcd, lives, led, done
  );
endinterface

// File: rtl/bcd_counter2.sv
// bcd_counter2: two-digit BCD counter with load, saturating inc/dec and limit flags
module bcd_counter2 #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] q,
  output logic       at_max,
  output logic       at_zero
);
  logic [7:0] q_inc, q_dec;
  assign at_max  = q == 8'h99;
  assign at_zero = q == 8'h00;
  assign q_inc = q[3:0] == 4'd9 ? {q[7:4] + 4'd1, 4'd0} : {q[7:4], q[3:0] + 4'd1};
  assign q_dec = q[3:0] == 4'd0 ? {q[7:4] - 4'd1, 4'd9} : {q[7:4], q[3:0] - 4'd1};
  // load wins over counting; inc/dec stop at 99/00 instead of wrapping
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RST_VAL;
    else if (load) q <= load_val;
    else if (inc && !at_max) q <= q_inc;
    else if (dec && !at_zero) q <= q_dec;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: lane-catch game flow FSM, lane position, score/time counters, LED patterns
// Optional lives tracking is enabled by defining GAME_LIVES_EN.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int LED_W      = 16,
  parameter int TIME_LIMIT = 60,
  parameter int WIN_SCORE  = 20,
  parameter int START_LANE = 0
) (
  input logic clk,
  input logic rst,
  game_ctrl_if.slave bus
);
  localparam int POS_W = $clog2(LANES);
  localparam logic [7:0] TIME_BCD = bcd_of(TIME_LIMIT);
  localparam logic [7:0] WIN_PREV = bcd_of(WIN_SCORE - 1);
  localparam logic [LED_W-1:0] ONES   = '1;
  localparam logic [LED_W-1:0] LED_55 = LED_W'(ALT_55);
  localparam logic [LED_W-1:0] LED_AA = LED_W'(ALT_AA);
  localparam logic [POS_W-1:0] LAST  = POS_W'(LANES - 1);
  localparam logic [POS_W-1:0] FIRST = POS_W'(START_LANE);
  state_t st;
  logic [POS_W-1:0] pos, pos_n;
  logic [LED_W-1:0] led, led_sh;
  logic [7:0] score, tim;
  logic [1:0] lives;
  logic done, in_game, arm, win, lose_time, lose_miss;
  logic s_max, s_zero, t_max, t_zero;
  assign in_game   = st == S_GAME;
  assign arm       = st == S_INIT && bus.start;
  // the hit that takes the score from WIN_SCORE-1 to WIN_SCORE ends the game
  assign win       = in_game && bus.hit && score == WIN_PREV;
  assign lose_time = in_game && bus.sec_tick && tim == 8'h01;
  assign pos_n = (bus.key_left && !bus.key_right && pos != LAST) ? pos + 1'b1 :
                 (bus.key_right && !bus.key_left && pos != '0) ? pos - 1'b1 : pos;
  assign led_sh = led[LED_W-1:1] == '0 ? ONES : led >> 1;
  bcd_counter2 #(.RST_VAL(8'h00)) u_score (
    .clk(clk), .rst(rst), .load(arm), .load_val(8'h00),
    .inc(in_game && bus.hit), .dec(1'b0),
    .q(score), .at_max(s_max), .at_zero(s_zero)
  );
  bcd_counter2 #(.RST_VAL(TIME_BCD)) u_time (
    .clk(clk), .rst(rst), .load(arm), .load_val(TIME_BCD),
    .inc(1'b0), .dec(in_game && bus.sec_tick),
    .q(tim), .at_max(t_max), .at_zero(t_zero)
  );
`ifdef GAME_LIVES_EN
  logic flags_unused;
  assign flags_unused = ^{s_max, s_zero, t_max, t_zero};
  assign lose_miss = in_game && bus.miss && lives == 2'd1;
  // lives refill when arming and drain on every miss during play
  always_ff @(posedge clk or negedge rst)
    if (!rst) lives <= 2'd3;
    else if (arm) lives <= 2'd3;
    else if (in_game && bus.miss && lives != 2'd0) lives <= lives - 2'd1;
`else
  logic flags_unused;
  assign flags_unused = ^{s_max, s_zero, t_max, t_zero, bus.miss};
  assign lives = 2'd0;
  assign lose_miss = 1'b0;
`endif
  // game flow FSM with registered lane, LED pattern and end-of-game pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st   <= S_INIT;
      pos  <= FIRST;
      led  <= ONES;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        S_INIT: begin
          led <= ONES;
          if (bus.start) begin
            st  <= S_SET;
            pos <= FIRST;
            led <= LED_55;
          end
        end
        S_SET:
          if (bus.start) begin
            st  <= S_GAME;
            led <= LED_W'(1) << pos;
          end else if (bus.led_tick) led <= ~led;
        S_GAME: begin
          pos <= pos_n;
          led <= LED_W'(1) << pos_n;
          if (win) begin
            st   <= S_WIN;
            led  <= ONES;
            done <= 1'b1;
          end else if (lose_time || lose_miss) begin
            st   <= S_LOSE;
            led  <= LED_AA;
            done <= 1'b1;
          end
        end
        S_WIN:
          if (bus.start) begin
            st  <= S_INIT;
            led <= ONES;
          end else if (bus.led_tick) led <= led_sh;
        S_LOSE:
          if (bus.start) begin
            st  <= S_INIT;
            led <= ONES;
          end else if (bus.led_tick) led <= ~led;
        default: st <= S_INIT;
      endcase
    end
  assign bus.state     = st;
  assign bus.pos       = pos;
  assign bus.score_bcd = score;
  assign bus.time_bcd  = tim;
  assign bus.lives     = lives;
  assign bus.led       = led;
  assign bus.done      = done;
endmodule
